// File: rtl/jtag_master.sv
// jtag_master: host-side JTAG sequencer.
// Turns word-level commands (TAP reset, IR scan, DR scan) into TCK/TMS/TDI
// waveforms and collects TDO into a response word.
//
// Ports:
//   clk, TRST          system clock, synchronous active-high reset
//   cmd_valid/ready    command handshake; cmd_type, cmd_len, cmd_data latched on accept
//   rsp_valid/ready    response handshake; rsp_data holds captured TDO bits
//   busy               high from command acceptance until cmd_ready re-asserts
//   TCK, TMS, TDI, TDO JTAG pins
//
// Optional feature: define JTAG_MASTER_IDLE_CYCLES_EN to add cmd_idle[7:0],
// the number of extra Run-Test/Idle TCK cycles emitted after an IR/DR scan.
module jtag_master #(
  parameter int unsigned TCK_DIV = 2,
  parameter int unsigned MAX_LEN = 32,
  parameter int unsigned LEN_W   = 6
) (
  input  logic               clk,
  input  logic               TRST,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_type,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
`ifdef JTAG_MASTER_IDLE_CYCLES_EN
  input  logic [7:0]         cmd_idle,
`endif
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               busy,
  output logic               TCK,
  output logic               TMS,
  output logic               TDI,
  input  logic               TDO
);

  localparam int unsigned PH_W  = $clog2(2 * TCK_DIV);
  localparam int unsigned CNT_W = (LEN_W > 8) ? LEN_W : 8;
  localparam logic [PH_W-1:0] PhRise = PH_W'(TCK_DIV - 1);
  localparam logic [PH_W-1:0] PhLast = PH_W'(2 * TCK_DIV - 1);

  typedef enum logic [3:0] {
    StRstSeq, StIdle, StSelDr, StSelIr, StCapture, StShift, StUpdate, StRtiRet, StResp
  } state_e;

  state_e             state_q, state_d;
  logic [PH_W-1:0]    ph_q, ph_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [MAX_LEN-1:0] data_q, data_d;
  logic [MAX_LEN-1:0] rsp_data_q, rsp_data_d;
  logic               tck_q, tck_d, tms_q, tms_d, tdi_q, tdi_d;
  logic               cmd_ready_q, cmd_ready_d, rsp_valid_q, rsp_valid_d, busy_q, busy_d;
  logic [CNT_W-1:0]   len_m1;
  logic [7:0]         idle_lim;
  logic               slot_end;

`ifdef JTAG_MASTER_IDLE_CYCLES_EN
  logic [7:0] idle_q, idle_d;
  assign idle_lim = idle_q;
`else
  assign idle_lim = 8'd0;
`endif

  assign len_m1 = CNT_W'(len_q) - CNT_W'(1);

  always_comb begin
    state_d     = state_q;
    ph_d        = ph_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    data_d      = data_q;
    rsp_data_d  = rsp_data_q;
    tck_d       = tck_q;
    tms_d       = tms_q;
    tdi_d       = tdi_q;
    cmd_ready_d = cmd_ready_q;
    rsp_valid_d = rsp_valid_q;
    busy_d      = busy_q;
    slot_end    = 1'b0;
`ifdef JTAG_MASTER_IDLE_CYCLES_EN
    idle_d      = idle_q;
`endif

    // Bit-slot timing: low half then high half; TDO sampled on the slot's last cycle.
    if (state_q != StIdle && state_q != StResp) begin
      if (ph_q == PhLast) begin
        ph_d     = '0;
        tck_d    = 1'b0;
        slot_end = 1'b1;
      end else begin
        ph_d = ph_q + 1'b1;
        if (ph_q == PhRise) tck_d = 1'b1;
      end
    end

    case (state_q)
      StIdle: begin
        if (!cmd_ready_q) begin
          // Trailing cycle after a no-op command.
          cmd_ready_d = 1'b1;
          busy_d      = 1'b0;
        end else if (cmd_valid) begin
          cmd_ready_d = 1'b0;
          busy_d      = 1'b1;
          data_d      = cmd_data;
          rsp_data_d  = '0;
          ph_d        = '0;
          cnt_d       = '0;
          tck_d       = 1'b0;
          tdi_d       = 1'b0;
          tms_d       = 1'b1;
`ifdef JTAG_MASTER_IDLE_CYCLES_EN
          idle_d      = cmd_idle;
`endif
          if (cmd_len == '0) len_d = LEN_W'(1);
          else if (cmd_len > LEN_W'(MAX_LEN)) len_d = LEN_W'(MAX_LEN);
          else len_d = cmd_len;
          case (cmd_type)
            2'd0:    state_d = StRstSeq;
            2'd1:    state_d = StSelIr;
            2'd2:    state_d = StSelDr;
            default: state_d = StIdle;
          endcase
        end
      end
      StRstSeq: if (slot_end) begin
        if (cnt_q == CNT_W'(5)) begin
          state_d     = StIdle;
          cmd_ready_d = 1'b1;
          busy_d      = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          tms_d = (cnt_q != CNT_W'(4));
        end
      end
      StSelDr: if (slot_end) begin
        state_d = StCapture;
        cnt_d   = '0;
        tms_d   = 1'b0;
      end
      StSelIr: if (slot_end) begin
        if (cnt_q == '0) begin
          cnt_d = CNT_W'(1);
        end else begin
          state_d = StCapture;
          cnt_d   = '0;
          tms_d   = 1'b0;
        end
      end
      // Two TMS=0 slots: Select -> Capture, Capture -> Shift.
      StCapture: if (slot_end) begin
        if (cnt_q == '0) begin
          cnt_d = CNT_W'(1);
        end else begin
          state_d = StShift;
          cnt_d   = '0;
          tms_d   = (len_q == LEN_W'(1));
          tdi_d   = data_q[0];
        end
      end
      StShift: if (slot_end) begin
        for (int i = 0; i < int'(MAX_LEN); i++) begin
          if (cnt_q == CNT_W'(i)) rsp_data_d[i] = TDO;
        end
        data_d = data_q >> 1;
        if (cnt_q == len_m1) begin
          state_d = StUpdate;
          tms_d   = 1'b1;
          tdi_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          tms_d = (cnt_q + CNT_W'(1) == len_m1);
          tdi_d = data_q[1];
        end
      end
      StUpdate: if (slot_end) begin
        state_d = StRtiRet;
        cnt_d   = '0;
        tms_d   = 1'b0;
      end
      // First slot lands in Run-Test/Idle, the rest are optional idle cycles.
      StRtiRet: if (slot_end) begin
        if (cnt_q == CNT_W'(idle_lim)) begin
          state_d     = StResp;
          rsp_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StResp: begin
        if (rsp_ready) begin
          state_d     = StIdle;
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          busy_d      = 1'b0;
        end
      end
      default: state_d = StRstSeq;
    endcase
  end

  always_ff @(posedge clk) begin
    if (TRST) begin
      state_q     <= StRstSeq;
      ph_q        <= '0;
      cnt_q       <= '0;
      len_q       <= '0;
      data_q      <= '0;
      rsp_data_q  <= '0;
      tck_q       <= 1'b0;
      tms_q       <= 1'b1;
      tdi_q       <= 1'b0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b1;
`ifdef JTAG_MASTER_IDLE_CYCLES_EN
      idle_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      ph_q        <= ph_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      data_q      <= data_d;
      rsp_data_q  <= rsp_data_d;
      tck_q       <= tck_d;
      tms_q       <= tms_d;
      tdi_q       <= tdi_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
`ifdef JTAG_MASTER_IDLE_CYCLES_EN
      idle_q      <= idle_d;
`endif
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = busy_q;
  assign TCK       = tck_q;
  assign TMS       = tms_q;
  assign TDI       = tdi_q;

endmodule

// File: tb/tb_jtag_master.sv
// Bench for jtag_master: drives commands into the sequencer, with a small
// behavioural TAP (4-bit IR, BYPASS at 4'hF, 32-bit data register at 4'h1)
// on the JTAG pins. Expected responses go into a scoreboard queue when a
// command is issued and are popped when the response arrives.
module tb_jtag_master;

  localparam logic [31:0] DCAP = 32'h8BAD_F00D;

  logic        clk = 1'b0;
  logic        TRST = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_type = 2'd0;
  logic [5:0]  cmd_len = 6'd0;
  logic [31:0] cmd_data = 32'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        busy, TCK, TMS, TDI;
  logic        TDO = 1'b0;
`ifdef JTAG_MASTER_IDLE_CYCLES_EN
  logic [7:0]  cmd_idle = 8'd0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_q[$];
  int          tck_edges = 0;
  logic [63:0] tms_bits  = '0;
  bit          rsp_seen  = 1'b0;

  always #5 clk = ~clk;

  jtag_master dut (
    .clk       (clk),
    .TRST      (TRST),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_type  (cmd_type),
    .cmd_len   (cmd_len),
    .cmd_data  (cmd_data),
`ifdef JTAG_MASTER_IDLE_CYCLES_EN
    .cmd_idle  (cmd_idle),
`endif
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .busy      (busy),
    .TCK       (TCK),
    .TMS       (TMS),
    .TDI       (TDI),
    .TDO       (TDO)
  );

  // ---------------- TAP model ----------------
  typedef enum logic [3:0] {
    TapTlr, TapRti, TapSds, TapCdr, TapShdr, TapE1dr, TapPdr, TapE2dr, TapUdr,
    TapSis, TapCir, TapShir, TapE1ir, TapPir, TapE2ir, TapUir
  } tap_e;

  tap_e        tap_st = TapTlr;
  logic [3:0]  ir = 4'h1;
  logic [3:0]  ir_sr = 4'h0;
  logic [31:0] dr_sr = 32'h0;

  always @(posedge TCK) begin
    case (tap_st)
      TapTlr:  begin tap_st <= TMS ? TapTlr : TapRti; ir <= 4'h1; end
      TapRti:  tap_st <= TMS ? TapSds : TapRti;
      TapSds:  tap_st <= TMS ? TapSis : TapCdr;
      TapCdr:  begin
        dr_sr  <= (ir == 4'hF) ? 32'h0 : DCAP;
        tap_st <= TMS ? TapE1dr : TapShdr;
      end
      TapShdr: begin
        dr_sr  <= (ir == 4'hF) ? {31'h0, TDI} : {TDI, dr_sr[31:1]};
        tap_st <= TMS ? TapE1dr : TapShdr;
      end
      TapE1dr: tap_st <= TMS ? TapUdr : TapPdr;
      TapPdr:  tap_st <= TMS ? TapE2dr : TapPdr;
      TapE2dr: tap_st <= TMS ? TapUdr : TapShdr;
      TapUdr:  tap_st <= TMS ? TapSds : TapRti;
      TapSis:  tap_st <= TMS ? TapTlr : TapCir;
      TapCir:  begin ir_sr <= 4'b0001; tap_st <= TMS ? TapE1ir : TapShir; end
      TapShir: begin ir_sr <= {TDI, ir_sr[3:1]}; tap_st <= TMS ? TapE1ir : TapShir; end
      TapE1ir: tap_st <= TMS ? TapUir : TapPir;
      TapPir:  tap_st <= TMS ? TapE2ir : TapPir;
      TapE2ir: tap_st <= TMS ? TapUir : TapShir;
      TapUir:  begin ir <= ir_sr; tap_st <= TMS ? TapSds : TapRti; end
      default: tap_st <= TapTlr;
    endcase
  end

  always @(negedge TCK) begin
    if (tap_st == TapShdr)      TDO <= dr_sr[0];
    else if (tap_st == TapShir) TDO <= ir_sr[0];
    else                        TDO <= 1'b0;
  end

  // ---------------- monitors ----------------
  always @(posedge TCK) begin
    if (tck_edges < 64) tms_bits[tck_edges] = TMS;
    tck_edges = tck_edges + 1;
  end

  always @(posedge clk) if (rsp_valid) rsp_seen = 1'b1;

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached, got running, need finished");
    $fatal(1);
  end

  // ---------------- helpers (stimulus only) ----------------
  function automatic logic [63:0] exp_tms(input bit is_ir, input int len);
    logic [63:0] v = '0;
    int k = 0;
    v[k] = 1'b1; k++;
    if (is_ir) begin v[k] = 1'b1; k++; end
    k += 2;
    k += len - 1;
    v[k] = 1'b1; k++;
    v[k] = 1'b1;
    return v;
  endfunction

  task automatic clear_log();
    tck_edges = 0;
    tms_bits  = '0;
    rsp_seen  = 1'b0;
  endtask

  task automatic wait_ready(output int cyc);
    cyc = 0;
    while (!cmd_ready && cyc < 300) begin
      @(posedge clk); #1; cyc++;
    end
  endtask

  task automatic issue(input logic [1:0] t, input logic [5:0] l, input logic [31:0] d);
    int c;
    wait_ready(c);
    cmd_type  = t;
    cmd_len   = l;
    cmd_data  = d;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output logic [31:0] d, output int cyc);
    cyc = 0;
    while (!rsp_valid && cyc < 600) begin
      @(posedge clk); #1; cyc++;
    end
    d = rsp_valid ? rsp_data : 32'hDEAD_BEEF;
  endtask

  task automatic ack_rsp();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int cyc;
    TRST = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (TCK !== 1'b0) begin n_fail++; $display("FAIL reset_tck: got %b need 0", TCK); end
    n_checks++; if (TMS !== 1'b1) begin n_fail++; $display("FAIL reset_tms: got %b need 1", TMS); end
    n_checks++; if (TDI !== 1'b0) begin n_fail++; $display("FAIL reset_tdi: got %b need 0", TDI); end
    n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL reset_cmd_ready: got %b need 0", cmd_ready); end
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b need 0", rsp_valid); end
    n_checks++; if (rsp_data !== 32'h0) begin n_fail++; $display("FAIL reset_rsp_data: got %h need 0", rsp_data); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL reset_busy: got %b need 1", busy); end
    clear_log();
    TRST = 1'b0;
    wait_ready(cyc);
    n_checks++; if (cyc < 23 || cyc > 25) begin n_fail++; $display("FAIL reset_latency: got %0d need 24", cyc); end
    n_checks++; if (tck_edges !== 6) begin n_fail++; $display("FAIL reset_edges: got %0d need 6", tck_edges); end
    n_checks++; if (tms_bits !== 64'h1F) begin n_fail++; $display("FAIL reset_tms_seq: got %h need 1f", tms_bits); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy_after: got %b need 0", busy); end
    n_checks++; if (tap_st !== TapRti) begin n_fail++; $display("FAIL reset_tap_state: got %0d need %0d", tap_st, TapRti); end
  endtask

  task automatic test_ir_bypass_dr();
    logic [31:0] got, exp;
    int cyc;
    clear_log();
    exp_q.push_back(32'h1);
    issue(2'd1, 6'd4, 32'hF);
    wait_rsp(got, cyc);
    ack_rsp();
    exp = exp_q.pop_front();
    n_checks++; if (got !== exp) begin n_fail++; $display("FAIL ir_rsp: got %h need %h", got, exp); end
    n_checks++; if (tck_edges !== 10) begin n_fail++; $display("FAIL ir_edges: got %0d need 10", tck_edges); end
    n_checks++; if (tms_bits !== exp_tms(1'b1, 4)) begin n_fail++; $display("FAIL ir_tms_seq: got %h need %h", tms_bits, exp_tms(1'b1, 4)); end
    n_checks++; if (ir !== 4'hF) begin n_fail++; $display("FAIL ir_loaded: got %h need f", ir); end

    clear_log();
    exp_q.push_back(32'h4A);
    issue(2'd2, 6'd8, 32'hA5);
    wait_rsp(got, cyc);
    ack_rsp();
    exp = exp_q.pop_front();
    n_checks++; if (got !== exp) begin n_fail++; $display("FAIL bypass_rsp: got %h need %h", got, exp); end
    n_checks++; if (cyc !== 52) begin n_fail++; $display("FAIL bypass_clk_cycles: got %0d need 52", cyc); end
    n_checks++; if (tck_edges !== 13) begin n_fail++; $display("FAIL bypass_edges: got %0d need 13", tck_edges); end
    n_checks++; if (tms_bits !== exp_tms(1'b0, 8)) begin n_fail++; $display("FAIL dr_tms_seq: got %h need %h", tms_bits, exp_tms(1'b0, 8)); end
  endtask

  task automatic test_len_bounds();
    logic [31:0] got, exp;
    int cyc;
    exp_q.push_back(32'h1);
    issue(2'd1, 6'd4, 32'h1);
    wait_rsp(got, cyc);
    ack_rsp();
    exp = exp_q.pop_front();
    n_checks++; if (got !== exp) begin n_fail++; $display("FAIL sel_data_ir_rsp: got %h need %h", got, exp); end

    clear_log();
    exp_q.push_back({31'h0, DCAP[0]});
    issue(2'd2, 6'd0, 32'h0);
    wait_rsp(got, cyc);
    ack_rsp();
    exp = exp_q.pop_front();
    n_checks++; if (got !== exp) begin n_fail++; $display("FAIL len0_rsp: got %h need %h", got, exp); end
    n_checks++; if (tck_edges !== 6) begin n_fail++; $display("FAIL len0_edges: got %0d need 6", tck_edges); end
    n_checks++; if (tms_bits !== exp_tms(1'b0, 1)) begin n_fail++; $display("FAIL len0_tms_seq: got %h need %h", tms_bits, exp_tms(1'b0, 1)); end

    clear_log();
    exp_q.push_back(DCAP);
    issue(2'd2, 6'd40, 32'h1234_5678);
    wait_rsp(got, cyc);
    ack_rsp();
    exp = exp_q.pop_front();
    n_checks++; if (got !== exp) begin n_fail++; $display("FAIL len40_rsp: got %h need %h", got, exp); end
    n_checks++; if (tck_edges !== 37) begin n_fail++; $display("FAIL len40_edges: got %0d need 37", tck_edges); end
  endtask

  task automatic test_rsp_hold_back_to_back();
    logic [31:0] got, exp;
    int cyc;
    bit stable = 1'b1;
    exp_q.push_back({24'h0, DCAP[7:0]});
    issue(2'd2, 6'd8, 32'h3C);
    wait_rsp(got, cyc);
    clear_log();
    exp = exp_q.pop_front();
    for (int i = 0; i < 20; i++) begin
      if (rsp_valid !== 1'b1 || rsp_data !== exp || cmd_ready !== 1'b0) stable = 1'b0;
      @(posedge clk); #1;
    end
    n_checks++; if (!stable) begin n_fail++; $display("FAIL hold_stable: got unstable rsp/cmd_ready need rsp_data %h held", exp); end
    n_checks++; if (tck_edges !== 0) begin n_fail++; $display("FAIL hold_edges: got %0d need 0", tck_edges); end
    n_checks++; if (rsp_data !== exp) begin n_fail++; $display("FAIL hold_rsp: got %h need %h", rsp_data, exp); end

    // Response handshake coincides with a new command request.
    exp_q.push_back({16'h0, DCAP[15:0]});
    cmd_type = 2'd2; cmd_len = 6'd16; cmd_data = 32'hFFFF;
    cmd_valid = 1'b1;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    n_checks++; if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL b2b_ready: got ready=%b valid=%b need ready=1 valid=0", cmd_ready, rsp_valid);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    n_checks++; if (cmd_ready !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL b2b_accept: got ready=%b busy=%b need ready=0 busy=1", cmd_ready, busy);
    end
    wait_rsp(got, cyc);
    ack_rsp();
    exp = exp_q.pop_front();
    n_checks++; if (got !== exp) begin n_fail++; $display("FAIL b2b_rsp: got %h need %h", got, exp); end
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL ack_ready: got %b need 1", cmd_ready); end
  endtask

  task automatic test_noop_and_tap_reset();
    logic [31:0] got, exp;
    int cyc;
    clear_log();
    issue(2'd3, 6'd8, 32'hFF);
    @(posedge clk); #1;
    n_checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL noop_ready: got ready=%b busy=%b need ready=1 busy=0", cmd_ready, busy);
    end
    n_checks++; if (tck_edges !== 0 || rsp_seen) begin
      n_fail++; $display("FAIL noop_quiet: got edges=%0d rsp=%b need 0 0", tck_edges, rsp_seen);
    end

    // Select BYPASS, then a TAP reset must bring the data register back.
    exp_q.push_back(32'h1);
    issue(2'd1, 6'd4, 32'hF);
    wait_rsp(got, cyc);
    ack_rsp();
    exp = exp_q.pop_front();
    n_checks++; if (got !== exp) begin n_fail++; $display("FAIL pre_reset_ir_rsp: got %h need %h", got, exp); end
    clear_log();
    issue(2'd0, 6'd0, 32'h0);
    wait_ready(cyc);
    n_checks++; if (tck_edges !== 6 || tms_bits !== 64'h1F) begin
      n_fail++; $display("FAIL tap_reset_seq: got edges=%0d tms=%h need 6 1f", tck_edges, tms_bits);
    end
    n_checks++; if (rsp_seen) begin n_fail++; $display("FAIL tap_reset_rsp: got response need none"); end
    exp_q.push_back(DCAP);
    issue(2'd2, 6'd32, 32'h0);
    wait_rsp(got, cyc);
    ack_rsp();
    exp = exp_q.pop_front();
    n_checks++; if (got !== exp) begin n_fail++; $display("FAIL post_tap_reset_dr: got %h need %h", got, exp); end
  endtask

  task automatic test_trst_mid_shift();
    logic [31:0] got, exp;
    int cyc = 0;
    clear_log();
    issue(2'd2, 6'd32, $urandom);
    // Edge 14 is the rising edge of shift bit 10.
    while (tck_edges < 14 && cyc < 500) begin
      @(posedge clk); #1; cyc++;
    end
    n_checks++; if (tck_edges < 14) begin n_fail++; $display("FAIL trst_reach_bit10: got %0d edges need 14", tck_edges); end
    TRST = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    clear_log();
    TRST = 1'b0;
    wait_ready(cyc);
    n_checks++; if (tck_edges !== 6 || tms_bits !== 64'h1F) begin
      n_fail++; $display("FAIL trst_seq: got edges=%0d tms=%h need 6 1f", tck_edges, tms_bits);
    end
    n_checks++; if (rsp_seen || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL trst_rsp: got response need none"); end
    exp_q.push_back(32'h1);
    issue(2'd1, 6'd4, 32'hF);
    wait_rsp(got, cyc);
    ack_rsp();
    exp = exp_q.pop_front();
    n_checks++; if (got !== exp) begin n_fail++; $display("FAIL trst_ir_rsp: got %h need %h", got, exp); end
    exp_q.push_back(32'hB4);
    issue(2'd2, 6'd8, 32'h5A);
    wait_rsp(got, cyc);
    ack_rsp();
    exp = exp_q.pop_front();
    n_checks++; if (got !== exp) begin n_fail++; $display("FAIL trst_bypass_rsp: got %h need %h", got, exp); end
  endtask

`ifdef JTAG_MASTER_IDLE_CYCLES_EN
  task automatic test_idle_cycles();
    logic [31:0] got, exp;
    int cyc;
    clear_log();
    cmd_idle = 8'd3;
    exp_q.push_back(32'h2E);
    issue(2'd2, 6'd8, 32'h17);
    cmd_idle = 8'd0;
    wait_rsp(got, cyc);
    ack_rsp();
    exp = exp_q.pop_front();
    n_checks++; if (got !== exp) begin n_fail++; $display("FAIL idle_rsp: got %h need %h", got, exp); end
    n_checks++; if (tck_edges !== 16) begin n_fail++; $display("FAIL idle_edges: got %0d need 16", tck_edges); end
    n_checks++; if (tms_bits !== exp_tms(1'b0, 8)) begin n_fail++; $display("FAIL idle_tms_seq: got %h need %h", tms_bits, exp_tms(1'b0, 8)); end
  endtask
`endif

  initial begin
    test_reset();
    test_ir_bypass_dr();
    test_len_bounds();
    test_rsp_hold_back_to_back();
    test_noop_and_tap_reset();
    test_trst_mid_shift();
`ifdef JTAG_MASTER_IDLE_CYCLES_EN
    test_idle_cycles();
`endif
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: got %0d left need 0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
